// File: rtl/ntt_stage_scheduler_if.sv
// Control/BRAM/butterfly bundle between the NTT stage scheduler and its surroundings.
// master = scheduler side, slave = top-level control + BRAM/butterfly side.
interface ntt_stage_scheduler_if #(
  parameter int unsigned HLEN = 7
);
  localparam int unsigned StageW = $clog2(HLEN + 2);

  logic                start;
  logic                busy;
  logic                done;
  logic [StageW-1:0]   stage;
  logic                src_pair;
  logic                result_pair;
  logic [3:0]          bram_en;
  logic [3:0]          bram_we;
  logic [4*HLEN-1:0]   bram_addr_a;
  logic [4*HLEN-1:0]   bram_addr_b;
  logic                bf_valid;
  logic [HLEN-1:0]     tw_idx;
  logic                wr_sel;

  modport master (
    input  start,
    output busy, done, stage, src_pair, result_pair, bram_en, bram_we,
           bram_addr_a, bram_addr_b, bf_valid, tw_idx, wr_sel
  );

  modport slave (
    output start,
    input  busy, done, stage, src_pair, result_pair, bram_en, bram_we,
           bram_addr_a, bram_addr_b, bf_valid, tw_idx, wr_sel
  );
endinterface

// File: rtl/ntt_stage_scheduler.sv
// Stage sequencer for a constant-geometry NTT over four ping-ponged BRAM banks.
// Reads one bank pair per stage; the delayed butterfly results are written to the other pair.
module ntt_stage_scheduler #(
  parameter int unsigned HLEN   = 7,
  parameter int unsigned BF_LAT = 4
) (
  input logic                   clk,
  input logic                   reset,
  ntt_stage_scheduler_if.master bus
);
  localparam int unsigned DEPTH  = 1 << HLEN;
  localparam int unsigned StageW = $clog2(HLEN + 2);
  localparam int unsigned CntW   = $clog2(BF_LAT + 1);
  // The last stage writes the pair opposite to the one it reads.
  localparam bit ResultPair = ((HLEN + 1) % 2) != 0;

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StNext, StDone} state_e;

  state_e                   state_q, state_d;
  logic [StageW-1:0]        stage_q, stage_d;
  logic [HLEN-1:0]          i_q, i_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [BF_LAT:0]          sr_v_q, sr_v_d;
  logic [BF_LAT:0][HLEN-1:0] sr_i_q, sr_i_d;

  logic                     rd_issue;
  logic                     done;
  logic                     src;
  logic [HLEN-1:0]          wr_i;
  logic [1:0]               wr_bank, rd_lo, rd_hi;
  logic [3:0]               en, we;
  logic [3:0][HLEN-1:0]     addr_a, addr_b;
  logic                     wr_sel;

  assign rd_issue = (state_q == StRun);

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          stage_d = '0;
          i_d     = '0;
        end
      end
      StRun: begin
        i_d = i_q + 1'b1;
        if (i_q == HLEN'(DEPTH - 1)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(BF_LAT)) begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (stage_q == StageW'(HLEN)) begin
          state_d = StDone;
        end else begin
          stage_d = stage_q + 1'b1;
          i_d     = '0;
          state_d = StRun;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Butterfly tracking pipe: entry 0 lines up with bf_valid, the last entry with the write.
  always_comb begin
    sr_v_d = {sr_v_q[BF_LAT-1:0], rd_issue};
    sr_i_d = {sr_i_q[BF_LAT-1:0], i_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      stage_q <= '0;
      i_q     <= '0;
      cnt_q   <= '0;
      sr_v_q  <= '0;
      sr_i_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      i_q     <= i_d;
      cnt_q   <= cnt_d;
      sr_v_q  <= sr_v_d;
      sr_i_q  <= sr_i_d;
    end
  end

  always_comb begin
    src     = stage_q[0];
    wr_i    = sr_i_q[BF_LAT];
    rd_lo   = {src, 1'b0};
    rd_hi   = {src, 1'b1};
    wr_bank = {~src, wr_i[HLEN-1]};
    en      = '0;
    we      = '0;
    addr_a  = '0;
    addr_b  = '0;
    wr_sel  = 1'b0;
    if (rd_issue) begin
      en[rd_lo]     = 1'b1;
      en[rd_hi]     = 1'b1;
      addr_a[rd_lo] = i_q;
      addr_a[rd_hi] = i_q;
    end
    // Butterfly i produces y[2i], y[2i+1]: same bank, adjacent addresses.
    if (sr_v_q[BF_LAT]) begin
      en[wr_bank]     = 1'b1;
      we[wr_bank]     = 1'b1;
      addr_a[wr_bank] = {wr_i[HLEN-2:0], 1'b0};
      addr_b[wr_bank] = {wr_i[HLEN-2:0], 1'b1};
      wr_sel          = wr_i[HLEN-1];
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done;
  assign bus.stage       = stage_q;
  assign bus.src_pair    = src;
  assign bus.result_pair = ResultPair;
  assign bus.bram_en     = en;
  assign bus.bram_we     = we;
  assign bus.bram_addr_a = addr_a;
  assign bus.bram_addr_b = addr_b;
  assign bus.bf_valid    = sr_v_q[0];
  assign bus.tw_idx      = sr_v_q[0] ? ((sr_i_q[0] >> stage_q) << stage_q) : '0;
  assign bus.wr_sel      = wr_sel;
endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Scoreboard bench: a small (HLEN=2, BF_LAT=2) and a default-sized scheduler run side by side;
// expected BRAM/butterfly events come from the coefficient layout, checked by a negedge monitor.
module tb_ntt_stage_scheduler;
  localparam int KRd = 0, KBf = 1, KWr = 2, KDone = 3;

  typedef struct {
    int id;
    int kind;
    int cyc;
    int a;
    int b;
    int c;
    int d;
  } ev_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  ev_t  ev_q[$];
  int   hlen_a[2]  = '{2, 7};
  int   bflat_a[2] = '{2, 4};
  int   per_a[2]   = '{8, 134};
  int   act_start[2] = '{-10, -10};
  int   act_done[2]  = '{-10, -10};

  ntt_stage_scheduler_if #(.HLEN(2)) bus0 ();
  ntt_stage_scheduler_if #(.HLEN(7)) bus1 ();

  ntt_stage_scheduler #(.HLEN(2), .BF_LAT(2)) u_small (
    .clk   (clk),
    .reset (rst0),
    .bus   (bus0)
  );

  ntt_stage_scheduler #(.HLEN(7), .BF_LAT(4)) u_big (
    .clk   (clk),
    .reset (rst1),
    .bus   (bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int id, input int kind, input int t, input int a, input int b,
                      input int c, input int d);
    ev_t e;
    e.id = id; e.kind = kind; e.cyc = t; e.a = a; e.b = b; e.c = c; e.d = d;
    ev_q.push_back(e);
  endtask

  // Reference: butterfly i of stage s reads x[i] (L bank) and x[i+D] (H bank) at address i,
  // and writes y[2i], y[2i+1] into the destination pair at coefficient position mod D.
  task automatic push_transform(input int id, input int c0);
    int hl, d, bl, p, t, src, dst, j, hb, bank;
    hl = hlen_a[id]; d = 1 << hl; bl = bflat_a[id]; p = per_a[id];
    for (int s = 0; s <= hl; s++) begin
      for (int i = 0; i < d; i++) begin
        t = c0 + 1 + s * p + i;
        src = s % 2;
        dst = 1 - src;
        j = 2 * i;
        hb = (j >= d) ? 1 : 0;
        bank = 2 * dst + hb;
        push(id, KRd, t, 3 << (2 * src), i, i, 0);
        push(id, KBf, t + 1, (i >> s) << s, 0, 0, 0);
        push(id, KWr, t + 1 + bl, 1 << bank, j % d, (j + 1) % d, hb);
      end
    end
    push(id, KDone, c0 + 1 + (hl + 1) * p, 0, 0, 0, 0);
    act_start[id] = c0;
    act_done[id]  = c0 + 1 + (hl + 1) * p;
  endtask

  function automatic bit model_busy(input int id);
    return (cyc > act_start[id]) && (cyc <= act_done[id]);
  endfunction

  task automatic do_start(input int id);
    if (id == 0) bus0.start = 1'b1; else bus1.start = 1'b1;
    if (!model_busy(id)) push_transform(id, cyc);
    tick();
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  task automatic do_reset(input int id, input bit with_start);
    if (id == 0) begin rst0 = 1'b1; bus0.start = with_start; end
    else begin rst1 = 1'b1; bus1.start = with_start; end
    for (int k = ev_q.size() - 1; k >= 0; k--) begin
      if (ev_q[k].id == id && ev_q[k].cyc > cyc) ev_q.delete(k);
    end
    if (act_done[id] > cyc) act_done[id] = cyc;
    tick();
    rst0 = 1'b0; rst1 = 1'b0;
    bus0.start = 1'b0; bus1.start = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    while (cyc <= act_done[id] + 1) tick();
  endtask

  task automatic take(input int id, input int kind, output ev_t e, output bit found);
    found = 1'b0;
    e = '{default: 0};
    for (int k = 0; k < ev_q.size(); k++) begin
      if (ev_q[k].id == id && ev_q[k].kind == kind) begin
        e = ev_q[k];
        ev_q.delete(k);
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic ev_cmp(input string nm, input int id, input bit found, input ev_t e,
                        input int a, input int b, input int c, input int d);
    n_chk++;
    if (!found) begin
      n_err++;
      $display("FAIL %s dut%0d: unexpected event at cyc %0d (a=%0d b=%0d c=%0d d=%0d)",
               nm, id, cyc, a, b, c, d);
    end else if (e.cyc != cyc || e.a != a || e.b != b || e.c != c || e.d != d) begin
      n_err++;
      $display("FAIL %s dut%0d: got cyc %0d a=%0d b=%0d c=%0d d=%0d, expected cyc %0d a=%0d b=%0d c=%0d d=%0d",
               nm, id, cyc, a, b, c, d, e.cyc, e.a, e.b, e.c, e.d);
    end
  endtask

  task automatic mon(input int id, input logic [3:0] en, input logic [3:0] we,
                     input logic [27:0] aa, input logic [27:0] ab, input logic bfv,
                     input logic [6:0] tw, input logic ws, input logic dn, input logic bsy,
                     input logic [3:0] stg, input logic sp);
    int hl, m, s, base, bank;
    logic [3:0] rdm, wrm;
    bit eb, found;
    ev_t e;
    hl = hlen_a[id];
    m = (1 << hl) - 1;
    rdm = en & ~we;
    wrm = en & we;
    eb = model_busy(id);
    chk($sformatf("busy dut%0d", id), longint'(bsy), longint'(eb));
    s = 0;
    if (eb) begin
      s = (cyc - act_start[id] - 1) / per_a[id];
      if (s > hl) s = hl;
      chk($sformatf("stage dut%0d", id), longint'(stg), s);
      chk($sformatf("src_pair dut%0d", id), longint'(sp), s % 2);
    end else if (en == 4'b0) begin
      chk($sformatf("idle_addr dut%0d", id), longint'(aa | ab), 0);
    end
    if (rdm != 4'b0) begin
      take(id, KRd, e, found);
      base = (e.a == 3) ? 0 : 2;
      ev_cmp("read", id, found, e, int'(rdm), int'(aa >> (base * hl)) & m,
             int'(aa >> ((base + 1) * hl)) & m,
             (int'(ab >> (base * hl)) & m) | (int'(ab >> ((base + 1) * hl)) & m));
    end
    if (wrm != 4'b0) begin
      chk($sformatf("write_hits_read_pair dut%0d", id),
          longint'(wrm & 4'(3 << (2 * (s % 2)))), 0);
      take(id, KWr, e, found);
      bank = (e.a == 8) ? 3 : (e.a == 4) ? 2 : (e.a == 2) ? 1 : 0;
      ev_cmp("write", id, found, e, int'(wrm), int'(aa >> (bank * hl)) & m,
             int'(ab >> (bank * hl)) & m, int'(ws));
    end
    if (bfv) begin
      take(id, KBf, e, found);
      ev_cmp("bf_valid/tw_idx", id, found, e, int'(tw), 0, 0, 0);
    end
    if (dn) begin
      take(id, KDone, e, found);
      ev_cmp("done", id, found, e, 0, 0, 0, 0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, bus0.bram_en, bus0.bram_we, {20'b0, bus0.bram_addr_a}, {20'b0, bus0.bram_addr_b},
          bus0.bf_valid, {5'b0, bus0.tw_idx}, bus0.wr_sel, bus0.done, bus0.busy,
          {2'b0, bus0.stage}, bus0.src_pair);
      mon(1, bus1.bram_en, bus1.bram_we, bus1.bram_addr_a, bus1.bram_addr_b,
          bus1.bf_valid, bus1.tw_idx, bus1.wr_sel, bus1.done, bus1.busy,
          bus1.stage, bus1.src_pair);
    end
  end

  task automatic chk_reset_state();
    chk("rst busy0", bus0.busy, 0);          chk("rst busy1", bus1.busy, 0);
    chk("rst done0", bus0.done, 0);          chk("rst done1", bus1.done, 0);
    chk("rst stage0", bus0.stage, 0);        chk("rst stage1", bus1.stage, 0);
    chk("rst src_pair0", bus0.src_pair, 0);  chk("rst src_pair1", bus1.src_pair, 0);
    chk("rst en0", bus0.bram_en, 0);         chk("rst en1", bus1.bram_en, 0);
    chk("rst we0", bus0.bram_we, 0);         chk("rst we1", bus1.bram_we, 0);
    chk("rst addr_a0", bus0.bram_addr_a, 0); chk("rst addr_a1", bus1.bram_addr_a, 0);
    chk("rst addr_b0", bus0.bram_addr_b, 0); chk("rst addr_b1", bus1.bram_addr_b, 0);
    chk("rst bf_valid0", bus0.bf_valid, 0);  chk("rst bf_valid1", bus1.bf_valid, 0);
    chk("rst tw_idx0", bus0.tw_idx, 0);      chk("rst tw_idx1", bus1.tw_idx, 0);
    chk("rst wr_sel0", bus0.wr_sel, 0);      chk("rst wr_sel1", bus1.wr_sel, 0);
    chk("result_pair0", bus0.result_pair, 1);
    chk("result_pair1", bus1.result_pair, 0);
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.start = 1'b0; bus1.start = 1'b0;
    repeat (3) tick();
    chk_reset_state();
    rst0 = 1'b0; rst1 = 1'b0;
    mon_en = 1'b1;
    tick();

    // Full small transform: done 25 cycles after start.
    do_start(0);
    wait_idle(0);
    repeat (3) tick();

    // Reset during the first stage-0 writes, then a clean rerun.
    do_start(0);
    repeat (5) tick();
    do_reset(0, 1'b0);
    repeat (30) tick();
    do_start(0);
    wait_idle(0);

    // Second start 10 cycles in must be ignored.
    do_start(0);
    repeat (9) tick();
    do_start(0);
    wait_idle(0);

    // Start coincident with reset: nothing begins.
    do_reset(0, 1'b1);
    repeat (30) tick();

    // Randomized starts, stray starts and resets on the small instance.
    for (int n = 0; n < 14; n++) begin
      repeat ($urandom_range(0, 5)) tick();
      do_start(0);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 27)) tick();
        do_reset(0, 1'($urandom_range(0, 1)));
      end else begin
        repeat ($urandom_range(0, 30)) tick();
        do_start(0);
      end
      wait_idle(0);
    end

    // Default-sized instance: full run, reset at a random point, full run again.
    do_start(1);
    wait_idle(1);
    do_start(1);
    repeat ($urandom_range(50, 1000)) tick();
    do_reset(1, 1'b0);
    repeat (20) tick();
    do_start(1);
    wait_idle(1);
    repeat (10) tick();

    mon_en = 1'b0;
    chk("leftover expected events", ev_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
